rx_packet_buffer: RTL and testbench

- Sits directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle ready pulse into a DEPTH-entry first-word-fall-through FIFO.
- Tags the most recently stored byte as end-of-packet when the receiver's end-of-packet pulse arrives.
- Presents bytes to the consumer over a valid/ready interface, with occupancy, complete-packet count and sticky overflow status.

---
 rtl/rx_packet_buffer.sv | 115 +++++++++++
 tb/tb_rx_packet_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_buffer.sv
// Receive-side packet buffer: captures UART bytes into a first-word-fall-through FIFO,
// tags end-of-packet on the newest stored byte and reports occupancy and packet count.
module rx_packet_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_neg,
    input  logic                  Exe_LogicImp,
    input  logic                  rx_dataout_ready,
    input  logic [7:0]            rx_dataout,
    input  logic                  rx_endofpacket,
    output logic [7:0]            buf_data,
    output logic                  buf_last,
    output logic                  buf_valid,
    input  logic                  buf_ready,
    output logic [ADDR_WIDTH:0]   buf_count,
    output logic                  buf_full,
    output logic [ADDR_WIDTH:0]   buf_pkt_count,
    output logic                  buf_overflow
);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH-1:0]      tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] eop_idx;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   pkt_q, pkt_d;
    logic                  overflow_q, overflow_d;
    logic                  pop, wr_en, tag_en;

    assign buf_data      = mem[rd_ptr_q];
    assign buf_last      = tag_q[rd_ptr_q];
    assign buf_valid     = (count_q != '0);
    assign buf_full      = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign buf_count     = count_q;
    assign buf_pkt_count = pkt_q;
    assign buf_overflow  = overflow_q;

    assign pop     = buf_valid & buf_ready;
    assign wr_en   = rx_dataout_ready & (~buf_full | pop);
    assign eop_idx = wr_ptr_q - ADDR_WIDTH'(1);
    // The newest byte may not be tagged while it is leaving the FIFO this cycle.
    assign tag_en  = rx_endofpacket & buf_valid & ~tag_q[eop_idx]
                     & ~((count_q == (ADDR_WIDTH+1)'(1)) & pop);

    always_comb begin
        tag_d      = tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pkt_d      = pkt_q;
        overflow_d = overflow_q | (rx_dataout_ready & buf_full & ~pop);

        if (pop) begin
            tag_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + ADDR_WIDTH'(1);
        end
        if (wr_en) begin
            tag_d[wr_ptr_q] = 1'b0;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (tag_en) begin
            tag_d[eop_idx] = 1'b1;
        end

        if (wr_en && !pop) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end

        if (tag_en && !(pop && buf_last)) begin
            pkt_d = pkt_q + (ADDR_WIDTH+1)'(1);
        end else if (!tag_en && pop && buf_last) begin
            pkt_d = pkt_q - (ADDR_WIDTH+1)'(1);
        end

        if (Exe_LogicImp) begin
            tag_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            pkt_d      = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_neg) begin
        if (!reset_neg) begin
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pkt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pkt_q      <= pkt_d;
            overflow_q <= overflow_d;
        end
    end

    // Data storage needs no reset; an entry is only observed after it has been written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= rx_dataout;
        end
    end

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Directed bench for rx_packet_buffer: queue-based packet model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_rx_packet_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clock = 1'b0;
    logic          reset_neg;
    logic          Exe_LogicImp;
    logic          rx_dataout_ready;
    logic [7:0]    rx_dataout;
    logic          rx_endofpacket;
    logic [7:0]    buf_data;
    logic          buf_last;
    logic          buf_valid;
    logic          buf_ready;
    logic [AW:0]   buf_count;
    logic          buf_full;
    logic [AW:0]   buf_pkt_count;
    logic          buf_overflow;

    int nvec = 0;
    int nmis = 0;

    rx_packet_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock            (clock),
        .reset_neg        (reset_neg),
        .Exe_LogicImp     (Exe_LogicImp),
        .rx_dataout_ready (rx_dataout_ready),
        .rx_dataout       (rx_dataout),
        .rx_endofpacket   (rx_endofpacket),
        .buf_data         (buf_data),
        .buf_last         (buf_last),
        .buf_valid        (buf_valid),
        .buf_ready        (buf_ready),
        .buf_count        (buf_count),
        .buf_full         (buf_full),
        .buf_pkt_count    (buf_pkt_count),
        .buf_overflow     (buf_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of {last, data}; packet count is simply the number of tagged entries.
    logic [8:0] q[$];
    bit         m_ovf;

    function automatic int m_pkts();
        int n = 0;
        foreach (q[i]) if (q[i][8]) n++;
        return n;
    endfunction

    always @(posedge clock or negedge reset_neg) begin
        if (!reset_neg || Exe_LogicImp) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            bit         do_pop;
            bit         was_full;
            logic [8:0] tmp;
            do_pop   = (q.size() != 0) && buf_ready;
            was_full = (q.size() == DEPTH);
            if (rx_endofpacket && q.size() != 0 && !(q.size() == 1 && do_pop)) begin
                tmp    = q[q.size()-1];
                tmp[8] = 1'b1;
                q[q.size()-1] = tmp;
            end
            if (do_pop) void'(q.pop_front());
            if (rx_dataout_ready) begin
                if (!was_full || do_pop) q.push_back({1'b0, rx_dataout});
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_neg) begin
            check("model_count", int'(buf_count), q.size());
            check("model_valid", int'(buf_valid), int'(q.size() != 0));
            check("model_full", int'(buf_full), int'(q.size() == DEPTH));
            check("model_pkts", int'(buf_pkt_count), m_pkts());
            check("model_ovf", int'(buf_overflow), int'(m_ovf));
            if (q.size() != 0) begin
                check("model_data", int'(buf_data), int'(q[0][7:0]));
                check("model_last", int'(buf_last), int'(q[0][8]));
            end else begin
                check("model_last_empty", int'(buf_last), 0);
            end
        end
    end

    // One clock cycle of stimulus, starting and ending at a falling edge.
    task automatic cyc(input bit rdy, input logic [7:0] d, input bit eop, input bit rd,
                       input bit clr);
        rx_dataout_ready = rdy;
        rx_dataout       = d;
        rx_endofpacket   = eop;
        buf_ready        = rd;
        Exe_LogicImp     = clr;
        @(negedge clock);
        rx_dataout_ready = 1'b0;
        rx_endofpacket   = 1'b0;
        buf_ready        = 1'b0;
        Exe_LogicImp     = 1'b0;
    endtask

    initial begin
        reset_neg        = 1'b0;
        Exe_LogicImp     = 1'b0;
        rx_dataout_ready = 1'b0;
        rx_dataout       = 8'h00;
        rx_endofpacket   = 1'b0;
        buf_ready        = 1'b0;
        @(negedge clock);
        check("rst_count", int'(buf_count), 0);
        check("rst_valid", int'(buf_valid), 0);
        check("rst_full", int'(buf_full), 0);
        check("rst_last", int'(buf_last), 0);
        check("rst_pkts", int'(buf_pkt_count), 0);
        check("rst_ovf", int'(buf_overflow), 0);
        reset_neg = 1'b1;
        @(negedge clock);

        // Three bytes in, nothing consumed
        cyc(1, 8'h41, 0, 0, 0);
        cyc(1, 8'h42, 0, 0, 0);
        cyc(1, 8'h43, 0, 0, 0);
        check("w3_count", int'(buf_count), 3);
        check("w3_valid", int'(buf_valid), 1);
        check("w3_data", int'(buf_data), 8'h41);
        check("w3_last", int'(buf_last), 0);
        check("w3_pkts", int'(buf_pkt_count), 0);

        // Tag, then drain
        cyc(0, 8'h00, 1, 0, 0);
        check("eop_pkts", int'(buf_pkt_count), 1);
        check("rd0_data", int'(buf_data), 8'h41);
        check("rd0_last", int'(buf_last), 0);
        cyc(0, 8'h00, 0, 1, 0);
        check("rd1_data", int'(buf_data), 8'h42);
        check("rd1_last", int'(buf_last), 0);
        cyc(0, 8'h00, 0, 1, 0);
        check("rd2_data", int'(buf_data), 8'h43);
        check("rd2_last", int'(buf_last), 1);
        check("rd2_pkts", int'(buf_pkt_count), 1);
        cyc(0, 8'h00, 0, 1, 0);
        check("drain_pkts", int'(buf_pkt_count), 0);
        check("drain_valid", int'(buf_valid), 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        check("fill_full", int'(buf_full), 1);
        check("fill_ovf", int'(buf_overflow), 0);
        cyc(1, 8'hFF, 0, 0, 0);
        check("ovf_flag", int'(buf_overflow), 1);
        check("ovf_count", int'(buf_count), 16);
        check("ovf_head", int'(buf_data), 8'h00);

        // Write while full with a simultaneous pop
        cyc(1, 8'hAA, 0, 1, 0);
        check("wp_count", int'(buf_count), 16);
        for (int k = 0; k < 16; k++) begin
            check("wrap_data", int'(buf_data), (k < 15) ? k + 1 : 8'hAA);
            cyc(0, 8'h00, 0, 1, 0);
        end
        check("wrap_empty", int'(buf_valid), 0);

        // End-of-packet corner cases
        cyc(0, 8'h00, 1, 0, 0);
        check("eop_empty_pkts", int'(buf_pkt_count), 0);
        cyc(1, 8'h55, 0, 0, 0);
        cyc(0, 8'h00, 1, 1, 0);
        check("eop_pop_pkts", int'(buf_pkt_count), 0);
        check("eop_pop_valid", int'(buf_valid), 0);
        cyc(1, 8'h07, 0, 0, 0);
        cyc(1, 8'h08, 1, 0, 0);
        check("eop_wr_pkts", int'(buf_pkt_count), 1);
        check("eop_wr_last", int'(buf_last), 1);
        cyc(0, 8'h00, 0, 1, 0);
        check("eop_wr_new_last", int'(buf_last), 0);
        cyc(1, 8'h09, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 0, 1, 0);
        check("tag_pend_pkts", int'(buf_pkt_count), 1);
        cyc(0, 8'h00, 0, 1, 0);
        check("tag_pend_empty", int'(buf_pkt_count), 0);
        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h12, 1, 0, 0);
        cyc(1, 8'h13, 1, 1, 0);
        check("tag_and_pop_pkts", int'(buf_pkt_count), 1);
        check("tag_and_pop_last", int'(buf_last), 1);
        cyc(0, 8'h00, 0, 1, 0);
        cyc(0, 8'h00, 0, 1, 0);
        check("tag_and_pop_done", int'(buf_pkt_count), 0);

        // Synchronous clear with overflow still sticky
        for (int i = 0; i < 5; i++) cyc(1, 8'h60 + 8'(i), 0, 0, 0);
        check("pre_clr_count", int'(buf_count), 5);
        check("pre_clr_ovf", int'(buf_overflow), 1);
        cyc(0, 8'h00, 0, 0, 1);
        check("clr_count", int'(buf_count), 0);
        check("clr_ovf", int'(buf_overflow), 0);
        check("clr_valid", int'(buf_valid), 0);
        cyc(1, 8'h99, 0, 0, 0);
        cyc(1, 8'h9A, 1, 0, 0);
        check("post_clr_data", int'(buf_data), 8'h99);

        // Asynchronous reset between clock edges
        cyc(1, 8'h9B, 0, 0, 0);
        #2;
        reset_neg = 1'b0;
        #1;
        check("areset_count", int'(buf_count), 0);
        check("areset_valid", int'(buf_valid), 0);
        check("areset_pkts", int'(buf_pkt_count), 0);
        check("areset_last", int'(buf_last), 0);
        check("areset_full", int'(buf_full), 0);
        @(negedge clock);
        reset_neg = 1'b1;
        cyc(1, 8'h33, 0, 0, 0);
        check("after_rst_data", int'(buf_data), 8'h33);
        cyc(0, 8'h00, 0, 1, 0);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
